uart_tx_arbiter: RTL and testbench

- Shares the single UART encoder between two byte-stream requesters: src 0 is the RX-FIFO echo stream, src 1 is the status/message generator.
- Grants are message-locked. Once a source owns the encoder, it keeps it until it sends a terminator byte or goes idle for a timeout period. Release then hands priority round-robin to the other source.
- Sits between the two byte sources and the encoder's ready/write handshake. No byte is dropped, duplicated or interleaved mid-message.

---
 rtl/uart_tx_arbiter_pkg.sv | 15 +
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_idle_timer.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 104 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter and its helpers.
package uart_tx_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    localparam logic SRC_ECHO   = 1'b0;
    localparam logic SRC_STATUS = 1'b1;

    localparam logic [7:0] DEFAULT_TERMINATOR = 8'h0A;
    localparam int         CLKS_PER_BIT       = 2604;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-source, encoder and status signals shared between the arbiter and its neighbours.
interface uart_tx_arbiter_if;

    logic       i_Src0_Valid;
    logic [7:0] i_Src0_Byte;
    logic       o_Src0_Take;
    logic       i_Src1_Valid;
    logic [7:0] i_Src1_Byte;
    logic       o_Src1_Take;
    logic       i_Enc_Ready;
    logic       o_Enc_Write;
    logic [7:0] o_Enc_Byte;
    logic [1:0] o_Grant;
    logic       o_Busy;

    modport slave (
        input  i_Src0_Valid, i_Src0_Byte, i_Src1_Valid, i_Src1_Byte, i_Enc_Ready,
        output o_Src0_Take, o_Src1_Take, o_Enc_Write, o_Enc_Byte, o_Grant, o_Busy
    );

    modport master (
        output i_Src0_Valid, i_Src0_Byte, i_Src1_Valid, i_Src1_Byte, i_Enc_Ready,
        input  o_Src0_Take, o_Src1_Take, o_Enc_Write, o_Enc_Byte, o_Grant, o_Busy
    );

endinterface

// File: rtl/uart_idle_timer.sv
// Saturating idle counter; o_Expired marks the TIMEOUT-th consecutive enabled cycle.
module uart_idle_timer #(
    parameter int TIMEOUT = 25000,
    parameter int W       = 15
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Expired
);

    localparam logic [W-1:0] LAST    = W'(TIMEOUT - 1);
    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            cnt <= '0;
        end else if (i_Clear) begin
            cnt <= '0;
        end else if (i_Enable && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

    // Pulse depends only on enable and count so callers may feed it back into clear.
    assign o_Expired = i_Enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-locked round-robin arbiter sharing one UART encoder between two byte sources.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter logic [7:0] TERMINATOR   = DEFAULT_TERMINATOR,
    parameter int         IDLE_TIMEOUT = 25000,
    parameter int         TIMEOUT_W    = 15
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    uart_tx_arbiter_if.slave bus
);

    arb_state_t state, state_nxt;
    logic       g, g_nxt;
    logic       ptr, ptr_nxt;
    logic       valid_g;
    logic [7:0] byte_g;
    logic       locked;
    logic       xfer;
    logic       term_rel;
    logic       expired;
    logic       timer_clear;
    logic       timer_en;

    assign locked   = (state == ST_LOCKED);
    assign valid_g  = (g == SRC_STATUS) ? bus.i_Src1_Valid : bus.i_Src0_Valid;
    assign byte_g   = (g == SRC_STATUS) ? bus.i_Src1_Byte  : bus.i_Src0_Byte;
    assign xfer     = locked && valid_g && bus.i_Enc_Ready;
    assign term_rel = xfer && (byte_g == TERMINATOR);

    // A stalled encoder keeps valid high, so only an empty owner advances the timer.
    assign timer_en    = locked && !valid_g;
    assign timer_clear = !locked || valid_g || expired;

    uart_idle_timer #(
        .TIMEOUT (IDLE_TIMEOUT),
        .W       (TIMEOUT_W)
    ) u_idle_timer (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_Clear   (timer_clear),
        .i_Enable  (timer_en),
        .o_Expired (expired)
    );

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state <= ST_IDLE;
            g     <= SRC_ECHO;
            ptr   <= SRC_ECHO;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        ptr_nxt   = ptr;
        case (state)
            ST_IDLE: begin
                if (bus.i_Src0_Valid && bus.i_Src1_Valid) begin
                    g_nxt     = ptr;
                    state_nxt = ST_LOCKED;
                end else if (bus.i_Src0_Valid) begin
                    g_nxt     = SRC_ECHO;
                    state_nxt = ST_LOCKED;
                end else if (bus.i_Src1_Valid) begin
                    g_nxt     = SRC_STATUS;
                    state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (term_rel || expired) begin
                    state_nxt = ST_IDLE;
                    ptr_nxt   = ~g;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are gated by reset so a mid-message reset suppresses the strobes immediately.
    always_comb begin
        bus.o_Busy      = 1'b0;
        bus.o_Grant     = 2'b00;
        bus.o_Enc_Byte  = 8'h00;
        bus.o_Enc_Write = 1'b0;
        bus.o_Src0_Take = 1'b0;
        bus.o_Src1_Take = 1'b0;
        if (i_Rst_L && locked) begin
            bus.o_Busy      = 1'b1;
            bus.o_Grant     = (g == SRC_STATUS) ? 2'b10 : 2'b01;
            bus.o_Enc_Byte  = byte_g;
            bus.o_Enc_Write = xfer;
            bus.o_Src0_Take = xfer && (g == SRC_ECHO);
            bus.o_Src1_Take = xfer && (g == SRC_STATUS);
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a short idle timeout.
module tb_uart_tx_arbiter;

    logic clk;
    logic rst_l;
    int   vectors;
    int   miscompares;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(
        .TERMINATOR   (8'h0A),
        .IDLE_TIMEOUT (4),
        .TIMEOUT_W    (15)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_l),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic wr, input logic [7:0] by,
                              input logic t0, input logic t1, input logic [1:0] gr,
                              input logic bs);
        chk({tag, ".write"}, {7'b0, bus.o_Enc_Write}, {7'b0, wr});
        chk({tag, ".byte"},  bus.o_Enc_Byte,          by);
        chk({tag, ".take0"}, {7'b0, bus.o_Src0_Take}, {7'b0, t0});
        chk({tag, ".take1"}, {7'b0, bus.o_Src1_Take}, {7'b0, t1});
        chk({tag, ".grant"}, {6'b0, bus.o_Grant},     {6'b0, gr});
        chk({tag, ".busy"},  {7'b0, bus.o_Busy},      {7'b0, bs});
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic rst, input logic v0, input logic [7:0] b0,
                         input logic v1, input logic [7:0] b1, input logic rdy);
        @(negedge clk);
        rst_l            = rst;
        bus.i_Src0_Valid = v0;
        bus.i_Src0_Byte  = b0;
        bus.i_Src1_Valid = v1;
        bus.i_Src1_Byte  = b1;
        bus.i_Enc_Ready  = rdy;
        #1;
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        rst_l            = 1'b0;
        bus.i_Src0_Valid = 1'b0;
        bus.i_Src0_Byte  = 8'h00;
        bus.i_Src1_Valid = 1'b0;
        bus.i_Src1_Byte  = 8'h00;
        bus.i_Enc_Ready  = 1'b0;

        drive(0, 0, 8'h00, 0, 8'h00, 1);
        drive(0, 0, 8'h00, 0, 8'h00, 1);
        expect_out("reset", 0, 8'h00, 0, 0, 2'b00, 0);

        // src0 "AB\n"
        drive(1, 1, 8'h41, 0, 8'h00, 1);
        expect_out("t1.arb", 0, 8'h00, 0, 0, 2'b00, 0);
        drive(1, 1, 8'h41, 0, 8'h00, 1);
        expect_out("t1.b41", 1, 8'h41, 1, 0, 2'b01, 1);
        drive(1, 1, 8'h42, 0, 8'h00, 1);
        expect_out("t1.b42", 1, 8'h42, 1, 0, 2'b01, 1);
        drive(1, 1, 8'h0A, 0, 8'h00, 1);
        expect_out("t1.b0a", 1, 8'h0A, 1, 0, 2'b01, 1);
        drive(1, 0, 8'h00, 0, 8'h00, 1);
        expect_out("t1.idle", 0, 8'h00, 0, 0, 2'b00, 0);

        // both valid from reset: src0 first, then src1
        drive(0, 0, 8'h00, 0, 8'h00, 1);
        drive(1, 1, 8'h58, 1, 8'h59, 1);
        expect_out("t2.arb", 0, 8'h00, 0, 0, 2'b00, 0);
        drive(1, 1, 8'h58, 1, 8'h59, 1);
        expect_out("t2.b58", 1, 8'h58, 1, 0, 2'b01, 1);
        drive(1, 1, 8'h0A, 1, 8'h59, 1);
        expect_out("t2.b0a0", 1, 8'h0A, 1, 0, 2'b01, 1);
        drive(1, 0, 8'h00, 1, 8'h59, 1);
        expect_out("t2.gap", 0, 8'h00, 0, 0, 2'b00, 0);
        drive(1, 0, 8'h00, 1, 8'h59, 1);
        expect_out("t2.b59", 1, 8'h59, 0, 1, 2'b10, 1);
        drive(1, 0, 8'h00, 1, 8'h0A, 1);
        expect_out("t2.b0a1", 1, 8'h0A, 0, 1, 2'b10, 1);
        drive(1, 0, 8'h00, 0, 8'h00, 1);
        expect_out("t2.idle", 0, 8'h00, 0, 0, 2'b00, 0);

        // src1 sends 53 then goes quiet; timeout after 4 idle cycles
        drive(1, 0, 8'h00, 1, 8'h53, 1);
        expect_out("t3.arb", 0, 8'h00, 0, 0, 2'b00, 0);
        drive(1, 0, 8'h00, 1, 8'h53, 1);
        expect_out("t3.b53", 1, 8'h53, 0, 1, 2'b10, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 8'h0A, 0, 8'h00, 1);
            expect_out($sformatf("t3.quiet%0d", i), 0, 8'h00, 0, 0, 2'b10, 1);
        end
        drive(1, 1, 8'h0A, 0, 8'h00, 1);
        expect_out("t3.released", 0, 8'h00, 0, 0, 2'b00, 0);
        drive(1, 1, 8'h0A, 0, 8'h00, 1);
        expect_out("t3.src0", 1, 8'h0A, 1, 0, 2'b01, 1);
        drive(1, 0, 8'h00, 0, 8'h00, 1);
        expect_out("t3.idle", 0, 8'h00, 0, 0, 2'b00, 0);

        // encoder stalled 50 cycles with owner valid
        drive(1, 1, 8'h37, 0, 8'h00, 0);
        expect_out("t4.arb", 0, 8'h00, 0, 0, 2'b00, 0);
        for (int i = 0; i < 50; i++) begin
            drive(1, 1, 8'h37, 0, 8'h00, 0);
            expect_out($sformatf("t4.stall%0d", i), 0, 8'h37, 0, 0, 2'b01, 1);
        end
        drive(1, 1, 8'h37, 0, 8'h00, 1);
        expect_out("t4.b37", 1, 8'h37, 1, 0, 2'b01, 1);
        drive(1, 1, 8'h0A, 0, 8'h00, 1);
        expect_out("t4.b0a", 1, 8'h0A, 1, 0, 2'b01, 1);
        drive(1, 0, 8'h00, 0, 8'h00, 1);
        expect_out("t4.idle", 0, 8'h00, 0, 0, 2'b00, 0);

        // reset mid-message while a transfer would fire
        drive(1, 1, 8'h41, 0, 8'h00, 1);
        expect_out("t5.arb", 0, 8'h00, 0, 0, 2'b00, 0);
        drive(1, 1, 8'h41, 0, 8'h00, 1);
        expect_out("t5.b41", 1, 8'h41, 1, 0, 2'b01, 1);
        drive(0, 1, 8'h42, 0, 8'h00, 1);
        expect_out("t5.rst", 0, 8'h00, 0, 0, 2'b00, 0);
        drive(1, 1, 8'h42, 1, 8'h59, 1);
        expect_out("t5.arb2", 0, 8'h00, 0, 0, 2'b00, 0);
        drive(1, 1, 8'h42, 1, 8'h59, 1);
        expect_out("t5.b42", 1, 8'h42, 1, 0, 2'b01, 1);
        drive(1, 1, 8'h0A, 1, 8'h59, 1);
        expect_out("t5.b0a0", 1, 8'h0A, 1, 0, 2'b01, 1);
        drive(1, 0, 8'h00, 1, 8'h59, 1);
        expect_out("t5.gap", 0, 8'h00, 0, 0, 2'b00, 0);
        drive(1, 0, 8'h00, 1, 8'h59, 1);
        expect_out("t5.b59", 1, 8'h59, 0, 1, 2'b10, 1);
        drive(1, 0, 8'h00, 1, 8'h0A, 1);
        expect_out("t5.b0a1", 1, 8'h0A, 0, 1, 2'b10, 1);
        drive(1, 0, 8'h00, 0, 8'h00, 1);
        expect_out("t5.idle", 0, 8'h00, 0, 0, 2'b00, 0);

        // back-to-back terminators from src0
        drive(1, 1, 8'h0A, 0, 8'h00, 1);
        expect_out("t6.arb0", 0, 8'h00, 0, 0, 2'b00, 0);
        drive(1, 1, 8'h0A, 0, 8'h00, 1);
        expect_out("t6.msg0", 1, 8'h0A, 1, 0, 2'b01, 1);
        drive(1, 1, 8'h0A, 0, 8'h00, 1);
        expect_out("t6.arb1", 0, 8'h00, 0, 0, 2'b00, 0);
        drive(1, 1, 8'h0A, 0, 8'h00, 1);
        expect_out("t6.msg1", 1, 8'h0A, 1, 0, 2'b01, 1);
        drive(1, 0, 8'h00, 0, 8'h00, 1);
        expect_out("t6.idle", 0, 8'h00, 0, 0, 2'b00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
